piso_shift_reg: RTL and testbench
=================================

Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register. It is the transmit-side counterpart of the team's serial-in, parallel-out bitshift register.
- Accepts an MSB-bit word through a valid/ready load handshake and emits it one bit per enabled clock.
- Shift order is MSB-first or LSB-first, selected per word.
- Used to drive the `d` input of a bitshift register, or any 1-bit serial link, from parallel datapath logic.

Parameters:
- MSB, 16, word width in bits; legal range MSB >= 2; bit counter width is $clog2(MSB).

Ports:
- clk  input  1  rising-edge clock for all state.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- en  input  1  shift enable; when low, the serial stream stalls.
- dir  input  1  shift order, sampled only at load: 0 = MSB-first (left shift), 1 = LSB-first (right shift).
- din  input  MSB  parallel word to serialize.
- load_valid  input  1  din/dir are valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- q  output  1  current serial bit.
- q_valid  output  1  q carries a live data bit.
- busy  output  1  state == SHIFT.
- done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset: any posedge with rstn=0 sets state=IDLE, shreg=0, cnt=0, dir_q=0, done=0.
  - Resulting outputs: q=0, q_valid=0, busy=0.
  - load_ready is forced 0 while rstn=0, so loads are ignored during reset.
  - Reset mid-word aborts the word with no done pulse; the next cycle is IDLE.
- Outputs:
  - q = dir_q ? shreg[0] : shreg[MSB-1] in SHIFT, else 0.
  - q_valid = busy.
- Handshake:
  - load_ready = rstn & (IDLE | (SHIFT & en & cnt==MSB-1)).
  - A load occurs on a posedge with load_valid & load_ready.
  - A load captures shreg<=din, dir_q<=dir, cnt<=0, state<=SHIFT.
  - load_valid with load_ready=0 is ignored; the source must hold it.
  - en does not gate loading from IDLE.
- IDLE:
  - No load: hold all state; q=0.
  - Load: go to SHIFT; the first bit appears on q in the cycle after the load edge.
- SHIFT, en=0: full stall; shreg, cnt, q and state are held; done=0.
- SHIFT, en=1, cnt<MSB-1: the current bit is consumed.
  - shreg shifts toward the output end: left for dir_q=0, right for dir_q=1.
  - The vacated bit is filled with 0.
  - cnt<=cnt+1.
- SHIFT, en=1, cnt==MSB-1: the last bit is consumed and done<=1 for exactly one cycle.
  - Simultaneous load: reload as above and stay in SHIFT. q_valid stays high with no bubble.
  - No load: state<=IDLE, shreg<=0.
- done is registered and 0 in every cycle that does not follow a last-bit edge.
- dir changes during SHIFT have no effect; only dir_q is used.
- Latency: load at edge N with en held 1.
  - Bits are presented in cycles N+1..N+MSB.
  - done is high in the cycle after edge N+MSB.
  - busy falls at that same edge unless a reload occurs.
- Every stalled en=0 cycle in SHIFT delays done by one cycle.
- Exactly MSB bits are emitted per accepted word.

Test Plan (MSB=16):
1. Reset:
   - Stimulus: rstn=0 for 2 clocks with load_valid=1.
   - Response: q=0, q_valid=0, busy=0, done=0, load_ready=0, nothing loaded.
   - After rstn=1: load_ready=1 on the next cycle.
2. MSB-first word:
   - Stimulus: load din=16'hA5C3, dir=0, en=1.
   - Response: q over 16 consecutive cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
   - done is high for 1 cycle after the 16th bit; busy=0, q=0 afterwards.
3. LSB-first word with dir toggled:
   - Stimulus: load din=16'h0001, dir=1; toggle dir every cycle during the shift.
   - Response: q = 1 then fifteen 0s; order unaffected by dir toggling.
4. Stall:
   - Stimulus: load 16'hA5C3, dir=0; after 4 bits, drive en=0 for 3 cycles.
   - Response: q holds 0 (bit 5) for the 3 stall cycles plus its own cycle.
   - Response: sequence otherwise unchanged; done arrives 3 cycles later than in scenario 2.
5. Back-to-back:
   - Stimulus: load 16'hA5C3; hold load_valid=1 with din=16'hFFFF, dir=1.
   - Response: load_ready=1 only during the last-bit cycle, where the second word is accepted.
   - Response: q_valid stays high for 32 cycles; the last 16 bits are all 1.
   - Response: done pulses twice, 16 cycles apart.
6. Reset mid-word:
   - Stimulus: load 16'hFFFF; drive rstn=0 for 1 clock after 5 bits.
   - Response: next cycle busy=0, q_valid=0, q=0; no done pulse.
   - Response: a fresh load after reset serializes correctly.

Source files
------------

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register.
// Accepts a word over a valid/ready handshake and emits it one bit per enabled
// clock, MSB-first or LSB-first as chosen at load time. A new word can be
// accepted in the last-bit cycle so back-to-back words stream without a bubble.
module piso_shift_reg #(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           dir,
  input  logic [MSB-1:0] din,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           q,
  output logic           q_valid,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(MSB);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_d;
  logic [MSB-1:0] shreg;
  logic [CW-1:0]  cnt;
  logic           dir_q;
  logic           last;
  logic           load;

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and handshake; a reload in the last-bit cycle keeps us in SHIFT.
  always_comb begin
    state_d    = state;
    last       = (state == SHIFT) && en && (cnt == CW'(MSB-1));
    load_ready = rstn && ((state == IDLE) || last);
    load       = load_valid && load_ready;
    if (load)      state_d = SHIFT;
    else if (last) state_d = IDLE;
  end

  // Datapath: capture on load, shift toward the output end on each enabled cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        shreg <= din;
        dir_q <= dir;
        cnt   <= '0;
      end else if (last) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (state == SHIFT && en) begin
        shreg <= dir_q ? (shreg >> 1) : (shreg << 1);
        cnt   <= cnt + CW'(1);
      end
    end
  end

  assign busy    = (state == SHIFT);
  assign q_valid = busy;
  assign q       = busy ? (dir_q ? shreg[0] : shreg[MSB-1]) : 1'b0;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg (MSB=16): reset, both shift orders,
// stall, back-to-back reload and mid-word reset.
module tb_piso_shift_reg;

  localparam int MSB = 16;

  logic           clk = 1'b0;
  logic           rstn, en, dir, load_valid;
  logic [MSB-1:0] din;
  logic           load_ready, q, q_valid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  piso_shift_reg #(.MSB(MSB)) dut (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .din(din),
    .load_valid(load_valid), .load_ready(load_ready),
    .q(q), .q_valid(q_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic expbit(input logic [MSB-1:0] w, input logic d, input int i);
    return d ? w[i] : w[MSB-1-i];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".q"},       32'(q),       32'd0);
    chk({tag, ".q_valid"}, 32'(q_valid), 32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
  endtask

  // Offer a word; the handshake must complete on the coming edge.
  task automatic load_word(input logic [MSB-1:0] w, input logic d);
    din = w; dir = d; load_valid = 1'b1; en = 1'b1;
    #1;
    chk("load.ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
  endtask

  // Check the serial stream of a word just loaded. Optional stall before bit
  // stall_at, optional dir toggling, and done expected in the first bit cycle
  // when the word was reloaded behind a previous one.
  task automatic serialize(input logic [MSB-1:0] w, input logic d, input int stall_at,
                           input int stall_len, input bit toggle, input logic first_done);
    for (int i = 0; i < MSB; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          en = 1'b0;
          chk("stall.q",    32'(q),       32'(expbit(w, d, i)));
          chk("stall.qv",   32'(q_valid), 32'd1);
          chk("stall.done", 32'(done),    (i == 0 && s == 0) ? 32'(first_done) : 32'd0);
          step();
        end
        en = 1'b1;
      end
      chk("bit.q",    32'(q),       32'(expbit(w, d, i)));
      chk("bit.qv",   32'(q_valid), 32'd1);
      chk("bit.done", 32'(done),    (i == 0 && stall_at != 0) ? 32'(first_done) : 32'd0);
      if (toggle) dir = ~dir;
      step();
    end
    chk("end.done", 32'(done), 32'd1);
    chk_idle("end");
    step();
    chk("post.done", 32'(done), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; dir = 1'b0; din = 16'hA5C3; load_valid = 1'b1;

    // 1. Reset with load_valid asserted: nothing loads.
    for (int k = 0; k < 2; k++) begin
      step();
      chk_idle("rst");
      chk("rst.done",  32'(done),       32'd0);
      chk("rst.ready", 32'(load_ready), 32'd0);
    end
    rstn = 1'b1; load_valid = 1'b0;
    #1;
    chk("rst.ready_after", 32'(load_ready), 32'd1);
    step();
    chk_idle("rst.after");

    // 2. MSB-first word 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
    load_word(16'hA5C3, 1'b0);
    serialize(16'hA5C3, 1'b0, -1, 0, 1'b0, 1'b0);

    // 3. LSB-first with dir toggling mid-word: 1 then fifteen 0s.
    load_word(16'h0001, 1'b1);
    serialize(16'h0001, 1'b1, -1, 0, 1'b1, 1'b0);
    dir = 1'b0;

    // 4. Stall three cycles before bit index 4.
    load_word(16'hA5C3, 1'b0);
    serialize(16'hA5C3, 1'b0, 4, 3, 1'b0, 1'b0);

    // 5. Back-to-back: second word accepted only in the last-bit cycle.
    load_word(16'hA5C3, 1'b0);
    din = 16'hFFFF; dir = 1'b1; load_valid = 1'b1;
    for (int i = 0; i < MSB; i++) begin
      #1;
      chk("b2b.q",     32'(q),          32'(expbit(16'hA5C3, 1'b0, i)));
      chk("b2b.ready", 32'(load_ready), (i == MSB-1) ? 32'd1 : 32'd0);
      chk("b2b.done",  32'(done),       32'd0);
      step();
    end
    load_valid = 1'b0;
    chk("b2b.qv_join", 32'(q_valid), 32'd1);
    serialize(16'hFFFF, 1'b1, -1, 0, 1'b0, 1'b1);

    // 6. Reset after five bits: abort with no done, then a fresh word.
    load_word(16'hFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("mid.q", 32'(q), 32'd1);
      step();
    end
    rstn = 1'b0; load_valid = 1'b1; din = 16'h1234;
    #1;
    chk("mid.ready_rst", 32'(load_ready), 32'd0);
    step();
    rstn = 1'b1; load_valid = 1'b0;
    chk_idle("mid.rst");
    chk("mid.done", 32'(done), 32'd0);
    step();
    chk("mid.done2", 32'(done), 32'd0);
    chk_idle("mid.idle");
    load_word(16'h1234, 1'b0);
    serialize(16'h1234, 1'b0, -1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
